// File: rtl/mem_access_ctrl.sv
// Memory-stage access initiator: runs one pipeline load/store as little-endian
// byte beats on a byte-wide memory port, stalling the pipeline meanwhile.
module mem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        word,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] read_data,
    output logic [31:0] m_address,
    output logic [7:0]  m_write_data,
    output logic        m_memRead,
    output logic        m_memWrite,
    input  logic [7:0]  m_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        op_write_q, op_write_d;
    logic        word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] read_data_q, read_data_d;

    logic        req;
    logic [32:0] end_addr;
    logic        last_beat;
    logic        in_beat;

    assign req       = memRead | memWrite;
    // One bit wider than the address so an access near 2^32 cannot wrap into range.
    assign end_addr  = {1'b0, address} + (word ? 33'd4 : 33'd1);
    assign last_beat = word_q ? (k_q == 2'd3) : 1'b1;
    assign in_beat   = (state_q == BEAT);

    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        k_d         = k_q;
        shadow_d    = shadow_q;
        read_data_d = read_data_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    op_write_d = memWrite;
                    word_d     = word;
                    addr_d     = address;
                    wdata_d    = write_data;
                    shadow_d   = 32'h0;
                    k_d        = 2'd0;
                    if (end_addr > 33'(MEM_BYTES)) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        fault_d = 1'b0;
                        state_d = BEAT;
                    end
                end
            end
            BEAT: begin
                if (!op_write_q) begin
                    shadow_d[{k_q, 3'b000} +: 8] = m_read_data;
                end
                if (last_beat) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE: begin
                if (!fault_q && !op_write_q) begin
                    read_data_d = word_q ? shadow_q : {24'h0, shadow_q[7:0]};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_write_q  <= 1'b0;
            word_q      <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            fault_q     <= 1'b0;
            k_q         <= 2'd0;
            shadow_q    <= 32'h0;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            k_q         <= k_d;
            shadow_q    <= shadow_d;
            read_data_q <= read_data_d;
        end
    end

    // Memory-port outputs depend only on registered state, never on the pipeline.
    assign m_address    = in_beat ? (addr_q + {30'd0, k_q}) : 32'h0;
    assign m_memWrite   = in_beat && op_write_q;
    assign m_memRead    = in_beat && !op_write_q;
    assign m_write_data = m_memWrite ? wdata_q[{k_q, 3'b000} +: 8] : 8'h0;

    assign stall     = !reset && (((state_q == IDLE) && req) || in_beat);
    assign done      = (state_q == DONE);
    assign fault     = done && fault_q;
    assign read_data = read_data_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access initiator that sits between the pipeline's memory stage and the byte-wide data memory. It accepts one load or store request (byte or word) from the pipeline and stalls the pipeline while it runs the access as byte beats on the memory port. Stores are split into little-endian bytes; loads are reassembled into a 32-bit result. Out-of-range accesses are rejected before any memory beat is issued.

## Interface
- MEM_BYTES, 14, data memory size in bytes; valid byte addresses are 0..MEM_BYTES-1
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- memRead  in  1  pipeline load request
- memWrite  in  1  pipeline store request; takes priority over memRead
- word  in  1  1 = 4-byte access (LDW/STW), 0 = byte access (LDB/STB)
- address  in  32  byte address of the access
- write_data  in  32  store data; byte k is bits [8k+7:8k]
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse at completion, including faulted requests
- fault  out  1  one-cycle pulse with done when the access exceeds MEM_BYTES
- read_data  out  32  load result, held until the next successful load
- m_address  out  32  byte address to memory
- m_write_data  out  8  byte to write
- m_memRead  out  1  byte read strobe
- m_memWrite  out  1  byte write strobe
- m_read_data  in  8  byte returned by memory, valid in the same cycle as m_memRead

## Operation
- States: IDLE, BEAT, DONE.
- **IDLE**
  - If memRead or memWrite is high, accept the request.
  - On accept, latch op (write if memWrite, else read), word, address and write_data.
  - Set beat count N = 4 if word, else 1.
  - If address + N > MEM_BYTES (33-bit compare, no wrap), go to DONE with the fault flag set. Otherwise clear the beat counter k and go to BEAT.
- **BEAT**
  - Drive m_address = latched address + k.
  - Write: m_memWrite = 1 and m_write_data = latched write_data[8k+7:8k].
  - Read: m_memRead = 1, and m_read_data is captured at the clock edge into shadow[8k+7:8k].
  - When k = N-1, go to DONE; otherwise increment k.
- **DONE**
  - done = 1; fault = the latched fault flag.
  - A successful read copies shadow into read_data at the edge that leaves DONE. A byte load zero-extends (bits 31:8 = 0). Writes and faults leave read_data unchanged.
  - Pipeline inputs are ignored in DONE. Always go to IDLE next.
- **stall**
  - High in IDLE when memRead or memWrite is high, and high throughout BEAT.
  - Low in DONE and in idle cycles with no request.
- m_* outputs are decoded from registered state only, with no combinational path from the pipeline inputs. Outside BEAT, m_memRead, m_memWrite and m_write_data are 0, and m_address is 0.
- The shadow register is cleared on accept.

## Timing
- Reset values: state IDLE, k = 0, read_data = 0, shadow = 0, stall/done/fault = 0, all m_* = 0.
- Reset mid-operation aborts the access. The next cycle is IDLE with no strobe, and a partially written word is not rolled back.
- Byte access: accept cycle t, beat at t+1, DONE at t+2. stall is high at t and t+1.
- Word access: beats at t+1 to t+4, DONE at t+5. stall is high from t to t+4.
- Fault: accept at t, DONE with fault at t+1, and no m_* strobe at any point. stall is high at t only.
- read_data is valid from cycle DONE+1 onward.
- The pipeline holds its request inputs while stall is high and advances after done.
- A request presented in the cycle after DONE is accepted normally, so back-to-back requests have no dead cycle.
- memRead and memWrite both high: treated as a write.

## Test plan
- **Reset then idle:** assert reset 2 cycles with memRead = 1 → all outputs 0. Release with no request → stall stays 0 and no m_* strobe.
- **Word store:** address = 4, write_data = 0xDEADBEEF, word = 1. Required beats: addr 4 = 0xEF, 5 = 0xBE, 6 = 0xAD, 7 = 0xDE. stall is high for 5 cycles, then done.
- **Loads after that store:**
  - Word load at address 4 (memory model returns the bytes above) → read_data = 0xDEADBEEF at DONE+1.
  - Byte load at address 6 → read_data = 0x000000AD.
- **Boundary fault:**
  - Word at address 11 (MEM_BYTES = 14) → done and fault pulse at t+1, no strobes, read_data unchanged.
  - Word at address 10 → succeeds, with the last beat at address 13.
  - address = 0xFFFFFFFE, word → fault, with no wrap.
- **Priority and back-to-back:** memRead = memWrite = 1, byte, address 2, write_data = 0x55 → a single write beat and no read. Then an immediate byte load at address 2 in the cycle after DONE → read_data = 0x00000055.
- **Reset mid-word:** assert reset during the second beat of a word store → no strobe in the following cycle, state IDLE, read_data = 0.
